dmem_unit: RTL and testbench

Parametrised data-memory stage for the Y86 processor. Replaces the fixed single-cycle data RAM and its separate read/write/address/data select helpers with one block. It decodes the memory operation from `icode`, checks the address, and performs the access over a configurable number of cycles. Request and response use valid/ready handshakes. It sits between execute (`valE`, `valA`, `valP`) and write-back (`valM`, `dmem_error`).

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_decode.sv | 62 ++++++
 rtl/dmem_unit.sv | 154 +++++++++++++++
 tb/tb_dmem_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and icode constants for the Y86 data-memory stage.
package dmem_pkg;

  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_decode.sv
// Combinational decode of a memory request: operation, word index, write data
// and address fault (range and optional alignment).
module dmem_decode
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH       = 8192,
  parameter int ALIGN_CHECK = 1,
  parameter int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output op_e               op,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] wdata,
  output logic              err
);

  localparam int WB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WB_A     = ADDR_W'(WB);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1) * WB_A;

  logic [ADDR_W-1:0] addr_s;
  logic              range_err_s;
  logic              align_err_s;

  // Select operation, address source and write data from the icode.
  always_comb begin
    op     = OP_NONE;
    addr_s = {ADDR_W{1'b0}};
    wdata  = {DATA_W{1'b0}};
    case (icode)
      ICODE_RMMOVQ: begin op = OP_WR; addr_s = valE;           wdata = valA; end
      ICODE_MRMOVQ: begin op = OP_RD; addr_s = valE;                          end
      ICODE_CALL:   begin op = OP_WR; addr_s = valE;           wdata = valP; end
      ICODE_RET:    begin op = OP_RD; addr_s = ADDR_W'(valA);                 end
      ICODE_PUSHQ:  begin op = OP_WR; addr_s = valE;           wdata = valA; end
      ICODE_POPQ:   begin op = OP_RD; addr_s = ADDR_W'(valA);                 end
      default:      begin op = OP_NONE;                                       end
    endcase
  end

  // Full-width compare so stray high address bits are still a fault.
  always_comb begin
    range_err_s = (addr_s > MAX_ADDR);
    if (ALIGN_CHECK != 0) begin
      align_err_s = ((addr_s % WB_A) != {ADDR_W{1'b0}});
    end else begin
      align_err_s = 1'b0;
    end
    if (op == OP_NONE) begin
      err = 1'b0;
    end else begin
      err = range_err_s | align_err_s;
    end
    idx = IDX_W'(addr_s / WB_A);
  end

endmodule

// File: rtl/dmem_unit.sv
// Y86 data-memory stage: decoded request is latched, held for ACC_LAT cycles,
// committed to storage, then presented as a valid/ready response.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH       = 8192,
  parameter int ACC_LAT     = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_LAT - 1);

  op_e               dec_op_s;
  logic [IDX_W-1:0]  dec_idx_s;
  logic [DATA_W-1:0] dec_wdata_s;
  logic              dec_err_s;

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  op_e               op_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic              err_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] valm_r;
  logic              dmem_error_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              commit_s;
  logic              wr_en_s;

  dmem_decode #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .ALIGN_CHECK (ALIGN_CHECK),
    .IDX_W       (IDX_W)
  ) u_decode (
    .icode (icode),
    .valE  (valE),
    .valA  (valA),
    .valP  (valP),
    .op    (dec_op_s),
    .idx   (dec_idx_s),
    .wdata (dec_wdata_s),
    .err   (dec_err_s)
  );

  // Commit happens on the last ACCESS edge; faulted writes never reach storage.
  always_comb begin
    if ((state_r == ACCESS) && (cnt_r == CNT_W'(0))) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
    if (commit_s && (op_r == OP_WR) && !err_r) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Control FSM with latched request and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_W'(0);
      op_r         <= OP_NONE;
      idx_r        <= IDX_W'(0);
      wdata_r      <= {DATA_W{1'b0}};
      err_r        <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      valm_r       <= {DATA_W{1'b0}};
      dmem_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          req_ready_r <= 1'b1;
          if (req_valid && req_ready_r) begin
            state_r     <= ACCESS;
            cnt_r       <= CNT_INIT;
            op_r        <= dec_op_s;
            idx_r       <= dec_idx_s;
            wdata_r     <= dec_wdata_s;
            err_r       <= dec_err_s;
            req_ready_r <= 1'b0;
          end
        end
        ACCESS: begin
          if (commit_s) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            dmem_error_r <= err_r;
            if ((op_r == OP_RD) && !err_r) begin
              valm_r <= mem_r[idx_r];
            end else begin
              valm_r <= {DATA_W{1'b0}};
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            valm_r       <= {DATA_W{1'b0}};
            dmem_error_r <= 1'b0;
            req_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          valm_r       <= {DATA_W{1'b0}};
          dmem_error_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; only committed writes update it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign valM       = valm_r;
  assign dmem_error = dmem_error_r;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: behavioural memory model plus directed ops.
module tb_dmem_unit;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 64;
  localparam int DEPTH   = 256;
  localparam int ACC_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  icode = 4'h0;
  logic [63:0] valE = 64'h0;
  logic [63:0] valA = 64'h0;
  logic [63:0] valP = 64'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] valM;
  logic        dmem_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = -1;

  typedef struct {
    logic [63:0]     valm;
    bit              valm_known;
    bit              err;
    int              acc_cyc;
    bit              seen;
    bit              is_wr;
    longint unsigned widx;
    logic [63:0]     wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem [longint unsigned];

  dmem_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACC_LAT(ACC_LAT), .ALIGN_CHECK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .icode(icode), .valE(valE), .valA(valA), .valP(valP),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .valM(valM), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // What the response to a request must be, from the Y86 memory rules.
  function automatic exp_t predict(input logic [3:0] ic, input logic [63:0] e,
                                   input logic [63:0] a, input logic [63:0] p);
    exp_t r;
    bit rd, wr, bad;
    longint unsigned addr;
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    addr = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    bad  = (rd || wr) && ((addr > longint'(DEPTH * 8 - 8)) || (addr % 8 != 0));
    r.err        = bad;
    r.is_wr      = wr && !bad;
    r.widx       = addr / 8;
    r.wdata      = (ic == 4'h8) ? p : a;
    r.seen       = 1'b0;
    r.acc_cyc    = cyc + 1;
    r.valm       = 64'h0;
    r.valm_known = 1'b1;
    if (rd && !bad) begin
      if (model_mem.exists(r.widx)) r.valm = model_mem[r.widx];
      else r.valm_known = 1'b0;
    end
    return r;
  endfunction

  // Compare process: checks every meaningful output cycle against the model.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      check("rst_req_ready", {63'h0, req_ready}, 64'h0);
      check("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
      check("rst_valM", valM, 64'h0);
      check("rst_dmem_error", {63'h0, dmem_error}, 64'h0);
    end else begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_resp", {63'h0, resp_valid}, 64'h0);
        end else begin
          if (!exp_q[0].seen) begin
            check("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(ACC_LAT));
            if (exp_q[0].is_wr) model_mem[exp_q[0].widx] = exp_q[0].wdata;
            exp_q[0].seen = 1'b1;
          end
          check("mon_dmem_error", {63'h0, dmem_error}, {63'h0, exp_q[0].err});
          if (exp_q[0].valm_known) check("mon_valM", valM, exp_q[0].valm);
          check("mon_req_ready_busy", {63'h0, req_ready}, 64'h0);
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(predict(icode, valE, valA, valP));
        last_acc_cyc = cyc + 1;
      end
    end
  end

  task automatic do_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, output logic [63:0] vm, output logic er);
    int n;
    @(negedge clk);
    icode = ic; valE = e; valA = a; valP = p; req_valid = 1'b1; resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout", 64'h0, 64'h1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("resp_timeout", 64'h0, 64'h1);
    vm = valM; er = dmem_error;
    @(negedge clk);
    check("retired", {63'h0, resp_valid}, 64'h0);
  endtask

  logic [63:0] vm, v0;
  logic        er, e0;
  int          retire_cyc;
  int          n;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_req_ready", {63'h0, req_ready}, 64'h0);
    check("reset_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("reset_valM", valM, 64'h0);
    check("reset_dmem_error", {63'h0, dmem_error}, 64'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_reset", {63'h0, req_ready}, 64'h1);

    do_op(4'h4, 64'h10, 64'hDEADBEEF, 64'h0, vm, er);
    check("wr_valM", vm, 64'h0);  check("wr_err", {63'h0, er}, 64'h0);
    do_op(4'h5, 64'h10, 64'h0, 64'h0, vm, er);
    check("rd_valM", vm, 64'hDEADBEEF);  check("rd_err", {63'h0, er}, 64'h0);

    do_op(4'h8, 64'h1F8, 64'h0, 64'h123, vm, er);
    check("call_err", {63'h0, er}, 64'h0);
    do_op(4'h9, 64'h0, 64'h1F8, 64'h0, vm, er);
    check("ret_valM", vm, 64'h123);

    do_op(4'h5, 64'(DEPTH * 8), 64'h0, 64'h0, vm, er);
    check("oob_err", {63'h0, er}, 64'h1);  check("oob_valM", vm, 64'h0);
    do_op(4'hA, 64'(DEPTH * 8 - 8), 64'h55, 64'h0, vm, er);
    check("top_word_wr_err", {63'h0, er}, 64'h0);
    do_op(4'hB, 64'h0, 64'(DEPTH * 8 - 8), 64'h0, vm, er);
    check("top_word_rd_valM", vm, 64'h55);  check("top_word_rd_err", {63'h0, er}, 64'h0);
    do_op(4'h5, 64'h8000_0000_0000_0010, 64'h0, 64'h0, vm, er);
    check("highbit_err", {63'h0, er}, 64'h1);
    do_op(4'h4, 64'h13, 64'h99, 64'h0, vm, er);
    check("misalign_err", {63'h0, er}, 64'h1);  check("misalign_valM", vm, 64'h0);
    do_op(4'h5, 64'h10, 64'h0, 64'h0, vm, er);
    check("after_misalign_valM", vm, 64'hDEADBEEF);

    do_op(4'h6, 64'h10, 64'h77, 64'h0, vm, er);
    check("nop_valM", vm, 64'h0);  check("nop_err", {63'h0, er}, 64'h0);
    do_op(4'h5, 64'h10, 64'h0, 64'h0, vm, er);
    check("after_nop_valM", vm, 64'hDEADBEEF);

    // Backpressure with a second request waiting behind the response.
    @(negedge clk);
    icode = 4'h5; valE = 64'h10; req_valid = 1'b1; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    icode = 4'h9; valE = 64'h0; valA = 64'h1F8;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("bp_resp_timeout", 64'h0, 64'h1);
    v0 = valM; e0 = dmem_error;
    check("bp_valM", v0, 64'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", {63'h0, resp_valid}, 64'h1);
      check("bp_valM_stable", valM, v0);
      check("bp_err_stable", {63'h0, dmem_error}, {63'h0, e0});
      check("bp_req_ready", {63'h0, req_ready}, 64'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    retire_cyc = cyc + 1;
    @(negedge clk);
    check("bp_req_ready_after", {63'h0, req_ready}, 64'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accept_cycle", 64'(last_acc_cyc), 64'(retire_cyc + 1));
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("bp2_resp_timeout", 64'h0, 64'h1);
    check("bp2_valM", valM, 64'h123);
    @(negedge clk);

    // Reset in the 2nd ACCESS cycle of a write: the write must be lost.
    do_op(4'h4, 64'h20, 64'h77, 64'h0, vm, er);
    @(negedge clk);
    icode = 4'h4; valE = 64'h20; valA = 64'hAA; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", {63'h0, req_ready}, 64'h0);
    check("async_rst_resp_valid", {63'h0, resp_valid}, 64'h0);
    check("async_rst_valM", valM, 64'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_midrst", {63'h0, req_ready}, 64'h1);
    do_op(4'h5, 64'h20, 64'h0, 64'h0, vm, er);
    check("lost_write_valM", vm, 64'h77);
    do_op(4'h5, 64'h10, 64'h0, 64'h0, vm, er);
    check("persist_valM", vm, 64'hDEADBEEF);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
